mem_seq_fsm: RTL and testbench

Parametrised control sequencer for the memory-sweep adder datapath. It walks a configurable address window of the word RAM and generates the strobes for the RAM, the accumulator and the result path: `rden`, `load`, `transf`, `wren` and `clear`. It adds a start/ready/done handshake, address wrap-around, and two modes: whole-window accumulate, and per-word running-sum write-back. The block sits between the top-level controller and the RAM/accumulator pair, replacing the fixed 32-word free-running sequencer.

---
 rtl/mem_seq_pkg.sv | 54 +++++
 rtl/mem_seq_fsm_addr_sweep.sv | 45 ++++
 rtl/mem_seq_fsm.sv | 98 +++++++++
 tb/tb_mem_seq_fsm.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/mem_seq_pkg.sv
// Shared types for the memory-sweep sequencer: FSM states, mode encodings
// and the registered strobe bundle decoded from each state.
package mem_seq_pkg;

  typedef enum logic [3:0] {
    IDLE,
    CLEAR,
    ADDR,
    RDEN,
    LOAD,
    UNLOAD,
    RDOFF,
    TRANSF,
    TOFF,
    WREN,
    WOFF,
    DONE
  } state_e;

  localparam logic MODE_ACCUM  = 1'b0;
  localparam logic MODE_WRBACK = 1'b1;

  typedef struct packed {
    logic rden;
    logic wren;
    logic load;
    logic transf;
    logic clear;
    logic ready;
    logic done;
  } strobes_t;

  // Moore decode: every strobe is a pure function of the state it belongs to.
  function automatic strobes_t decode_strobes(input state_e st);
    strobes_t s;
    s = '0;
    case (st)
      IDLE:   s.ready  = 1'b1;
      CLEAR:  s.clear  = 1'b1;
      RDEN:   s.rden   = 1'b1;
      LOAD: begin
        s.rden = 1'b1;
        s.load = 1'b1;
      end
      UNLOAD: s.rden   = 1'b1;
      TRANSF: s.transf = 1'b1;
      WREN:   s.wren   = 1'b1;
      DONE:   s.done   = 1'b1;
      default: s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mem_seq_fsm_addr_sweep.sv
// Address window walker: holds the current RAM address and counts down the
// words still to visit after the current one.
module addr_sweep #(
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_en,
  input  logic              adv_en,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W-1:0] address,
  output logic              last
);

  logic [ADDR_W-1:0] addr_d, addr_q;
  logic [ADDR_W-1:0] rem_d,  rem_q;

  // rem holds N-1, so modular subtraction covers both the wrap and N=2^ADDR_W.
  always_comb begin
    addr_d = addr_q;
    rem_d  = rem_q;
    if (load_en) begin
      addr_d = first_addr;
      rem_d  = last_addr - first_addr;
    end else if (adv_en) begin
      addr_d = addr_q + 1'b1;
      rem_d  = rem_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      addr_q <= '0;
      rem_q  <= '0;
    end else begin
      addr_q <= addr_d;
      rem_q  <= rem_d;
    end
  end

  assign address = addr_q;
  assign last    = (rem_q == '0);

endmodule

// File: rtl/mem_seq_fsm.sv
// Control sequencer for the memory-sweep adder: walks an address window and
// emits RAM / accumulator / result strobes with a start/ready/done handshake.
module mem_seq_fsm
  import mem_seq_pkg::*;
#(
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W-1:0] address,
  output logic              rden,
  output logic              wren,
  output logic              load,
  output logic              transf,
  output logic              clear,
  output logic              ready,
  output logic              done
);

  state_e   state_d, state_q;
  logic     mode_d,  mode_q;
  strobes_t out_d,   out_q;
  logic     load_en, adv_en, last;

  assign load_en = (state_q == IDLE) && start;
  assign adv_en  = ((state_q == RDOFF) && (mode_q == MODE_ACCUM) && !last) ||
                   ((state_q == WOFF) && !last);

  addr_sweep #(
    .ADDR_W(ADDR_W)
  ) u_addr_sweep (
    .clk       (clk),
    .reset     (reset),
    .load_en   (load_en),
    .adv_en    (adv_en),
    .first_addr(first_addr),
    .last_addr (last_addr),
    .address   (address),
    .last      (last)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      mode_q  <= MODE_ACCUM;
      out_q   <= decode_strobes(IDLE);
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      out_q   <= out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = CLEAR;
        mode_d  = mode;
      end
      CLEAR:  state_d = ADDR;
      ADDR:   state_d = RDEN;
      RDEN:   state_d = LOAD;
      LOAD:   state_d = UNLOAD;
      UNLOAD: state_d = RDOFF;
      RDOFF: begin
        if (mode_q == MODE_WRBACK || last) state_d = TRANSF;
        else                               state_d = ADDR;
      end
      TRANSF: state_d = TOFF;
      TOFF:   state_d = (mode_q == MODE_WRBACK) ? WREN : DONE;
      WREN:   state_d = WOFF;
      WOFF:   state_d = last ? DONE : ADDR;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes are decoded from the next state and registered alongside it,
  // so they change on the same edge as the state they describe.
  always_comb begin
    out_d = decode_strobes(state_d);
  end

  assign rden   = out_q.rden;
  assign wren   = out_q.wren;
  assign load   = out_q.load;
  assign transf = out_q.transf;
  assign clear  = out_q.clear;
  assign ready  = out_q.ready;
  assign done   = out_q.done;

endmodule

// File: tb/tb_mem_seq_fsm.sv
// Self-checking bench for mem_seq_fsm: cycle-accurate expected traces built
// per word from the sequencing rules, plus a strobe-spacing monitor.
module tb_mem_seq_fsm;

  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          reset, start, mode;
  logic [AW-1:0] first_addr, last_addr, address;
  logic          rden, wren, load, transf, clear, ready, done;

  int err_cnt = 0;
  int chk_cnt = 0;
  bit mon_en  = 1'b0;

  mem_seq_fsm #(.ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .first_addr(first_addr), .last_addr(last_addr), .address(address),
    .rden(rden), .wren(wren), .load(load), .transf(transf),
    .clear(clear), .ready(ready), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [11:0] pk(input logic [4:0] a, input logic r, w, ld, t, c, rdy, d);
    return {a, r, w, ld, t, c, rdy, d};
  endfunction

  function automatic logic [11:0] obs();
    return {address, rden, wren, load, transf, clear, ready, done};
  endfunction

  // One sweep: queue index k is the expected output after edge k (edge 0 samples start).
  task automatic run_sweep(input logic m, input logic [4:0] f, input logic [4:0] l, input bit hold);
    logic [11:0] q[$];
    logic [4:0]  a, d;
    int          n, done_k, exp_done;
    d = l - f;
    n = int'(d) + 1;
    q.push_back(pk(f, 0, 0, 0, 0, 1, 0, 0));
    for (int i = 0; i < n; i++) begin
      a = 5'((int'(f) + i) % 32);
      q.push_back(pk(a, 0, 0, 0, 0, 0, 0, 0));
      q.push_back(pk(a, 1, 0, 0, 0, 0, 0, 0));
      q.push_back(pk(a, 1, 0, 1, 0, 0, 0, 0));
      q.push_back(pk(a, 1, 0, 0, 0, 0, 0, 0));
      q.push_back(pk(a, 0, 0, 0, 0, 0, 0, 0));
      if (m) begin
        q.push_back(pk(a, 0, 0, 0, 1, 0, 0, 0));
        q.push_back(pk(a, 0, 0, 0, 0, 0, 0, 0));
        q.push_back(pk(a, 0, 1, 0, 0, 0, 0, 0));
        q.push_back(pk(a, 0, 0, 0, 0, 0, 0, 0));
      end
    end
    if (!m) begin
      q.push_back(pk(l, 0, 0, 0, 1, 0, 0, 0));
      q.push_back(pk(l, 0, 0, 0, 0, 0, 0, 0));
    end
    q.push_back(pk(l, 0, 0, 0, 0, 0, 0, 1));
    q.push_back(pk(l, 0, 0, 0, 0, 0, 1, 0));

    mode = m; first_addr = f; last_addr = l; start = 1'b1;
    done_k = -1;
    for (int k = 0; k < q.size(); k++) begin
      @(posedge clk); @(negedge clk);
      check_eq("trace", 32'(obs()), 32'(q[k]));
      if (done) done_k = k;
      if (k < q.size() - 2) begin
        mode       = 1'($urandom);
        first_addr = 5'($urandom);
        last_addr  = 5'($urandom);
        start      = hold ? 1'b1 : ($urandom_range(7) == 0);
      end else begin
        start = hold;
      end
    end
    exp_done = m ? (1 + 9 * n) : (3 + 5 * n);
    check_eq("done_edge", done_k, exp_done);
  endtask

  logic          p_rden, p_load, p_transf, p_wren;
  logic [AW-1:0] p_addr;
  bit            p_valid = 1'b0;

  always @(negedge clk) begin
    if (mon_en && p_valid) begin
      check_eq("load_transf_excl", 32'(load & transf), 0);
      if (address !== p_addr) check_eq("addr_vs_rden_edge", 32'(rden != p_rden), 0);
      if (load && !p_load)    check_eq("load_rise_after_rden", 32'(p_rden), 1);
      if (!rden && p_rden)    check_eq("rden_fall_after_load", 32'(p_load), 0);
      if (wren != p_wren)     check_eq("wren_vs_transf", 32'({transf, p_transf}), 0);
    end
    p_rden = rden; p_load = load; p_transf = transf; p_wren = wren; p_addr = address;
    p_valid = 1'b1;
  end

  initial begin
    int dones;
    reset = 1'b0; start = 1'b0; mode = 1'b0; first_addr = '0; last_addr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_state", 32'(obs()), 32'(pk(0, 0, 0, 0, 0, 0, 1, 0)));
    reset = 1'b1;
    mon_en = 1'b1;

    run_sweep(1'b0, 5'd0,  5'd31, 1'b0);
    run_sweep(1'b1, 5'd30, 5'd1,  1'b0);
    run_sweep(1'b0, 5'd7,  5'd7,  1'b0);
    run_sweep(1'b1, 5'd7,  5'd7,  1'b0);
    run_sweep(1'b1, 5'd3,  5'd5,  1'b1);
    run_sweep(1'b0, 5'd10, 5'd12, 1'b1);
    run_sweep(1'b0, 5'd31, 5'd0,  1'b0);
    for (int s = 0; s < 12; s++)
      run_sweep(1'($urandom), 5'($urandom), 5'($urandom), ($urandom_range(3) == 0));

    // Abort mid-sweep while load is high.
    mode = 1'b0; first_addr = 5'd5; last_addr = 5'd20; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    check_eq("pre_reset_load", 32'(obs()), 32'(pk(5, 1, 0, 1, 0, 0, 0, 0)));
    mon_en = 1'b0;
    reset = 1'b0;
    for (int e = 0; e < 3; e++) begin
      @(posedge clk); @(negedge clk);
      check_eq("reset_abort", 32'(obs()), 32'(pk(0, 0, 0, 0, 0, 0, 1, 0)));
    end
    reset = 1'b1;
    dones = 0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); @(negedge clk);
      if (done) dones++;
    end
    check_eq("no_done_after_abort", dones, 0);
    check_eq("idle_after_abort", 32'(obs()), 32'(pk(0, 0, 0, 0, 0, 0, 1, 0)));
    mon_en = 1'b1;
    run_sweep(1'b1, 5'd2, 5'd4, 1'b0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
